// File: rtl/instruction_encoder.sv
// ============================================================================
//  Module   : instruction_encoder
//  Packs an immediate into an RV32 instruction word (I/S/B/U/J formats)
//  behind a 2-entry valid/ready FIFO. Optional range checking of the
//  immediate is enabled by defining the macro RANGE_CHECK_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_encoder (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_valid,
  output logic        O_ready,
  input  logic [2:0]  I_immsel,
  input  logic [31:0] I_imm,
  input  logic [31:0] I_base,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_data,
  output logic        O_err
);

  // Format select codes, matching the immediate generator's decode.
  localparam logic [2:0] IMM_ITYPE = 3'd0;
  localparam logic [2:0] IMM_STYPE = 3'd1;
  localparam logic [2:0] IMM_BTYPE = 3'd2;
  localparam logic [2:0] IMM_UTYPE = 3'd3;
  localparam logic [2:0] IMM_JTYPE = 3'd4;

  logic [31:0] enc_word;
  logic        enc_err;

  always_comb begin
    enc_word = I_base;
    case (I_immsel)
      IMM_ITYPE: enc_word = {I_imm[11:0], I_base[19:0]};
      IMM_STYPE: enc_word = {I_imm[11:5], I_base[24:12], I_imm[4:0], I_base[6:0]};
      IMM_BTYPE: enc_word = {I_imm[12], I_imm[10:5], I_base[24:12],
                             I_imm[4:1], I_imm[11], I_base[6:0]};
      IMM_UTYPE: enc_word = {I_imm[31:12], I_base[11:0]};
      IMM_JTYPE: enc_word = {I_imm[20], I_imm[10:1], I_imm[11],
                             I_imm[19:12], I_base[11:0]};
      default:   enc_word = I_base;
    endcase
  end

`ifdef RANGE_CHECK_EN
  // A field is in range when all of its upper bits replicate the sign.
  always_comb begin
    enc_err = 1'b1;
    case (I_immsel)
      IMM_ITYPE,
      IMM_STYPE: enc_err = !((&I_imm[31:11]) || !(|I_imm[31:11]));
      IMM_BTYPE: enc_err = !((&I_imm[31:12]) || !(|I_imm[31:12])) || I_imm[0];
      IMM_JTYPE: enc_err = !((&I_imm[31:20]) || !(|I_imm[31:20])) || I_imm[0];
      IMM_UTYPE: enc_err = |I_imm[11:0];
      default:   enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  logic [32:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        started;
  logic        push;
  logic        pop;

  assign O_ready = started && (count != 2'd2);
  assign O_valid = (count != 2'd0);
  assign push    = I_valid && O_ready;
  assign pop     = O_valid && I_ready;
  assign O_data  = mem[rd_ptr][32:1];
  assign O_err   = mem[rd_ptr][0];

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (push) begin
        mem[wr_ptr] <= {enc_word, enc_err};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire
